// File: rtl/pm_mem_arbiter.sv
// Single-port RAM arbiter: the ROM loader owns the RAM while a download is running;
// otherwise the CPU and PRC share it round-robin. Optional wait counters: `PM_ARB_STATS_EN.
module pm_mem_arbiter #(
  parameter int AW     = 21,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ld_active,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          prc_req,
  input  logic [AW-1:0] prc_addr,
  output logic          prc_gnt,
  output logic          prc_rvalid,
  output logic [DW-1:0] rdata,
`ifdef PM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_cpu_wait,
  output logic [15:0]   stat_prc_wait,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_PRC = 1'b1;

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [RD_LAT-1:0]   tag_vld_q;
  logic [RD_LAT-1:0]   tag_own_q;
  logic                cpu_rvalid_q, prc_rvalid_q;
  logic [DW-1:0]       rdata_q;

  logic                ld_gnt_s, cpu_gnt_s, prc_gnt_s;
  logic                issue_vld_s, issue_own_s;
  logic                mem_en_s, mem_we_s;
  logic [AW-1:0]       mem_addr_s;
  logic [DW-1:0]       mem_wdata_s;

  // Grant selection, mode transitions and RAM port steering; nothing is granted while in reset.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    ld_gnt_s    = 1'b0;
    cpu_gnt_s   = 1'b0;
    prc_gnt_s   = 1'b0;
    issue_vld_s = 1'b0;
    issue_own_s = OWN_CPU;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (reset_n) begin
      case (state_q)
        ST_RUN: begin
          if (cpu_req && (!prc_req || (rr_last_q == OWN_PRC))) begin
            cpu_gnt_s = 1'b1;
          end else begin
            prc_gnt_s = prc_req;
          end
          if (ld_active) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_LOAD: begin
          ld_gnt_s = ld_req;
          if (!ld_active) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_DRAIN: begin
          if (tag_vld_q == '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end else begin
      state_d = ST_RUN;
    end

    if (ld_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = ld_addr;
      mem_wdata_s = ld_wdata;
    end else if (cpu_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = cpu_we;
      mem_addr_s  = cpu_addr;
      mem_wdata_s = cpu_wdata;
      issue_vld_s = !cpu_we;
      issue_own_s = OWN_CPU;
      rr_last_d   = OWN_CPU;
    end else if (prc_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_addr_s  = prc_addr;
      issue_vld_s = 1'b1;
      issue_own_s = OWN_PRC;
      rr_last_d   = OWN_PRC;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Mode and round-robin history.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      rr_last_q <= OWN_PRC;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Read tags travel alongside the RAM latency so returned data reaches the right owner.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q[0] <= issue_vld_s;
      tag_own_q[0] <= issue_own_s;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  // Registered read return: one extra cycle after the RAM output, one owner at a time.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid_q <= 1'b0;
      prc_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      cpu_rvalid_q <= tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == OWN_CPU);
      prc_rvalid_q <= tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == OWN_PRC);
      if (tag_vld_q[RD_LAT-1]) begin
        rdata_q <= mem_rdata;
      end
    end
  end

`ifdef PM_ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_prc_q;

  // Saturating wait counters; a clear pulse beats a same-cycle increment.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stat_cpu_q <= 16'd0;
      stat_prc_q <= 16'd0;
    end else if (stat_clr) begin
      stat_cpu_q <= 16'd0;
      stat_prc_q <= 16'd0;
    end else begin
      if ((state_q == ST_RUN) && cpu_req && !cpu_gnt_s && (stat_cpu_q != 16'hFFFF)) begin
        stat_cpu_q <= stat_cpu_q + 16'd1;
      end
      if ((state_q == ST_RUN) && prc_req && !prc_gnt_s && (stat_prc_q != 16'hFFFF)) begin
        stat_prc_q <= stat_prc_q + 16'd1;
      end
    end
  end

  assign stat_cpu_wait = stat_cpu_q;
  assign stat_prc_wait = stat_prc_q;
`endif

  assign ld_gnt     = ld_gnt_s;
  assign cpu_gnt    = cpu_gnt_s;
  assign prc_gnt    = prc_gnt_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign prc_rvalid = prc_rvalid_q;
  assign rdata      = rdata_q;
  assign mem_en     = mem_en_s;
  assign mem_we     = mem_we_s;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_pm_mem_arbiter.sv
// Bench for pm_mem_arbiter: directed scenarios plus random traffic checked against a
// cycle-level reference model (grant rules, shadow memory, queue of pending read returns).
module tb_pm_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_active = 1'b0, ld_req = 1'b1;
  logic [20:0] ld_addr = 21'd0;
  logic [7:0]  ld_wdata = 8'd0;
  logic        ld_gnt;
  logic        cpu_req = 1'b1, cpu_we = 1'b0;
  logic [20:0] cpu_addr = 21'h20;
  logic [7:0]  cpu_wdata = 8'd0;
  logic        cpu_gnt, cpu_rvalid;
  logic        prc_req = 1'b1;
  logic [20:0] prc_addr = 21'h40;
  logic        prc_gnt, prc_rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
`ifdef PM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cpu_wait, stat_prc_wait;
  logic [15:0] m_cpu_wait, m_prc_wait;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  pm_mem_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ld_active(ld_active), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .prc_req(prc_req), .prc_addr(prc_addr), .prc_gnt(prc_gnt), .prc_rvalid(prc_rvalid),
    .rdata(rdata),
`ifdef PM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cpu_wait(stat_cpu_wait), .stat_prc_wait(stat_prc_wait),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM environment (1-cycle read latency) and the model's own shadow copy.
  logic [7:0] ram_mem [0:8191];
  logic [7:0] shadow  [0:8191];

  initial begin
    for (int a = 0; a < 8192; a++) begin
      ram_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      shadow[a]  = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    end
    ram_mem[4096] = 8'h5A;
    shadow[4096]  = 8'h5A;
  end

  always @(posedge clk_sys) begin
    if (mem_en) begin
      if (mem_we) ram_mem[mem_addr[12:0]] <= mem_wdata;
      else        mem_rdata <= ram_mem[mem_addr[12:0]];
    end
  end

  // Reference model: modes, round-robin history, pending read returns keyed by due cycle.
  typedef struct { int due; logic own_prc; logic [7:0] data; } rd_t;
  rd_t rq[$];
  localparam int M_RUN = 0, M_LOAD = 1, M_DRAIN = 2;
  int   m_mode = M_RUN;
  logic m_last_prc = 1'b1;
  int   cyc = 0;

  always @(negedge clk_sys) begin
    logic e_ld, e_cpu, e_prc, e_en, x_cpu_rv, x_prc_rv;
    logic [7:0] x_rd;
    rd_t ent;
    cyc++;
    if (!reset_n) begin
      check("rst_gnt", {29'd0, ld_gnt, cpu_gnt, prc_gnt}, 32'd0);
      check("rst_rvalid", {30'd0, cpu_rvalid, prc_rvalid}, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      rq.delete();
      m_mode = M_RUN;
      m_last_prc = 1'b1;
`ifdef PM_ARB_STATS_EN
      m_cpu_wait = 16'd0;
      m_prc_wait = 16'd0;
`endif
    end else begin
      e_ld = 1'b0; e_cpu = 1'b0; e_prc = 1'b0;
      if (m_mode == M_RUN) begin
        if (cpu_req && prc_req) begin
          e_cpu = m_last_prc;
          e_prc = !m_last_prc;
        end else begin
          e_cpu = cpu_req;
          e_prc = prc_req;
        end
      end else if (m_mode == M_LOAD) begin
        e_ld = ld_req;
      end
      e_en = e_ld | e_cpu | e_prc;
      check("ld_gnt", {31'd0, ld_gnt}, {31'd0, e_ld});
      check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cpu});
      check("prc_gnt", {31'd0, prc_gnt}, {31'd0, e_prc});
      check("mem_en", {31'd0, mem_en}, {31'd0, e_en});
      if (e_en) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, e_ld | (e_cpu & cpu_we)});
        check("mem_addr", {11'd0, mem_addr}, {11'd0, e_ld ? ld_addr : (e_cpu ? cpu_addr : prc_addr)});
        if (e_ld) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, ld_wdata});
        else if (e_cpu && cpu_we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, cpu_wdata});
      end
      x_cpu_rv = 1'b0; x_prc_rv = 1'b0; x_rd = 8'd0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        x_prc_rv = rq[0].own_prc;
        x_cpu_rv = !rq[0].own_prc;
        x_rd     = rq[0].data;
        void'(rq.pop_front());
      end
      check("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, x_cpu_rv});
      check("prc_rvalid", {31'd0, prc_rvalid}, {31'd0, x_prc_rv});
      if (x_cpu_rv || x_prc_rv) check("rdata", {24'd0, rdata}, {24'd0, x_rd});
`ifdef PM_ARB_STATS_EN
      check("stat_cpu_wait", {16'd0, stat_cpu_wait}, {16'd0, m_cpu_wait});
      check("stat_prc_wait", {16'd0, stat_prc_wait}, {16'd0, m_prc_wait});
      if (stat_clr) begin
        m_cpu_wait = 16'd0;
        m_prc_wait = 16'd0;
      end else begin
        if (m_mode == M_RUN && cpu_req && !e_cpu && m_cpu_wait != 16'hFFFF) m_cpu_wait++;
        if (m_mode == M_RUN && prc_req && !e_prc && m_prc_wait != 16'hFFFF) m_prc_wait++;
      end
`endif
      if (e_ld) shadow[ld_addr[12:0]] = ld_wdata;
      if (e_cpu) begin
        m_last_prc = 1'b0;
        if (cpu_we) begin
          shadow[cpu_addr[12:0]] = cpu_wdata;
        end else begin
          ent.due = cyc + 2; ent.own_prc = 1'b0; ent.data = shadow[cpu_addr[12:0]];
          rq.push_back(ent);
        end
      end
      if (e_prc) begin
        m_last_prc = 1'b1;
        ent.due = cyc + 2; ent.own_prc = 1'b1; ent.data = shadow[prc_addr[12:0]];
        rq.push_back(ent);
      end
      if (m_mode == M_RUN && ld_active) m_mode = M_LOAD;
      else if (m_mode == M_LOAD && !ld_active) m_mode = M_DRAIN;
      else if (m_mode == M_DRAIN && rq.size() == 0) m_mode = M_RUN;
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic cg, pg;
    int ld_left;
    // Reset held with every request asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("t1_no_gnt", {29'd0, ld_gnt, cpu_gnt, prc_gnt}, 32'd0);
    end
    step();
    reset_n = 1'b0;
    ld_req  = 1'b0;
    reset_n = 1'b1;
    // Contention straight out of reset: CPU first, then alternating; returns in the same order.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (i < 8) begin
        check("t3_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, (i % 2 == 0)});
        check("t3_prc_gnt", {31'd0, prc_gnt}, {31'd0, (i % 2 == 1)});
      end
      if (i >= 2) begin
        check("t3_cpu_rv", {31'd0, cpu_rvalid}, {31'd0, (i % 2 == 0)});
        check("t3_prc_rv", {31'd0, prc_rvalid}, {31'd0, (i % 2 == 1)});
      end
      step();
      if (i == 7) begin
        cpu_req = 1'b0;
        prc_req = 1'b0;
      end
    end
`ifdef PM_ARB_STATS_EN
    @(negedge clk_sys);
    check("t6_cpu_wait", {16'd0, stat_cpu_wait}, 32'd4);
    check("t6_prc_wait", {16'd0, stat_prc_wait}, 32'd4);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk_sys);
    check("t6_clr", {stat_cpu_wait, stat_prc_wait}, 32'd0);
    step();
`endif
    // Single CPU read of a preloaded location.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1000;
    @(negedge clk_sys);
    check("t2_gnt", {31'd0, cpu_gnt}, 32'd1);
    step();
    cpu_req = 1'b0;
    @(negedge clk_sys);
    check("t2_rv_early", {31'd0, cpu_rvalid}, 32'd0);
    step();
    @(negedge clk_sys);
    check("t2_rv", {31'd0, cpu_rvalid}, 32'd1);
    check("t2_rdata", {24'd0, rdata}, 32'h5A);
    step();
    // ROM load of 16 bytes while the CPU keeps asking.
    ld_active = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      ld_req = 1'b1; ld_addr = 21'(i); ld_wdata = 8'(i);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'd7;
      @(negedge clk_sys);
      check("t4_ld_gnt", {31'd0, ld_gnt}, 32'd1);
      check("t4_cpu_blk", {31'd0, cpu_gnt}, 32'd0);
      step();
    end
    ld_req = 1'b0; ld_active = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk_sys);
      if (cpu_gnt) break;
      cnt++;
      step();
    end
    check("t4_gnt_wait", {31'd0, (cnt < 10)}, 32'd1);
    step();
    cpu_req = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk_sys);
      if (cpu_rvalid) break;
      cnt++;
      step();
    end
    check("t4_rv_wait", {31'd0, (cnt < 10)}, 32'd1);
    check("t4_rdata", {24'd0, rdata}, 32'h07);
    step();
    // Read in flight when the loader takes over: still returns exactly once.
    cpu_req = 1'b1; cpu_addr = 21'd3;
    step();
    cpu_req = 1'b0; ld_active = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (cpu_rvalid) cnt++;
      step();
    end
    check("t5_rv_once", cnt, 32'd1);
    ld_active = 1'b0;
    repeat (4) step();
    // Reset during an in-flight read: no return afterwards.
    cpu_req = 1'b1; cpu_addr = 21'd4;
    step();
    cpu_req = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (cpu_rvalid || prc_rvalid) cnt++;
      step();
    end
    check("t5_rst_no_rv", cnt, 32'd0);
    // Random traffic with occasional loads and resets.
    ld_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      cg = cpu_gnt;
      pg = prc_gnt;
      step();
      reset_n = 1'b1;
      if (cg) cpu_req = 1'b0;
      if (pg) prc_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 99) < 45) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 21'($urandom_range(0, 63)); cpu_wdata = 8'($urandom);
      end
      if (!prc_req && $urandom_range(0, 99) < 45) begin
        prc_req = 1'b1; prc_addr = 21'($urandom_range(0, 63));
      end
      ld_req = 1'($urandom_range(0, 1));
      ld_addr = 21'($urandom_range(0, 63)); ld_wdata = 8'($urandom);
      if (ld_active) begin
        if (ld_left == 0) ld_active = 1'b0;
        else ld_left--;
      end else if ($urandom_range(0, 149) == 0) begin
        ld_active = 1'b1;
        ld_left = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
    end
    step();
    reset_n = 1'b1; cpu_req = 1'b0; prc_req = 1'b0; ld_req = 1'b0; ld_active = 1'b0;
    repeat (6) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
